// File: rtl/calc_result_bcd.sv
// Serial double-dabble formatter for the 4-bit calculator datapath.
// Converts one raw result per handshake into hundreds/tens/ones plus remainder digits.
`timescale 1ns/1ps
module calc_result_bcd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_bcd,
    output logic [7:0]  out_rem,
    output logic        out_neg,
    output logic [1:0]  out_op
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t      state;
    logic [2:0]  count;
    logic [7:0]  main_sh, rem_sh;
    logic [11:0] main_bcd;
    logic [7:0]  rem_bcd;
    logic        neg_r;
    logic [1:0]  op_r;

    logic [7:0]  cap_main, cap_rem;
    logic        cap_neg;
    logic [3:0]  sub_mag;
    logic [11:0] main_adj, main_nxt;
    logic [7:0]  rem_adj, rem_nxt;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Sub arrives as the raw a+~b+1 sum; bit 4 is the no-borrow flag.
    always_comb begin
        cap_main = 8'd0;
        cap_rem  = 8'd0;
        cap_neg  = 1'b0;
        sub_mag  = ~in_data[3:0] + 4'd1;
        case (in_op)
            2'b00: cap_main = {3'b000, in_data[4:0]};
            2'b01: begin
                cap_main = in_data[4] ? {4'h0, in_data[3:0]} : {4'h0, sub_mag};
                cap_neg  = ~in_data[4] && (cap_main != 8'd0);
            end
            2'b10: cap_main = in_data;
            default: begin
                cap_main = {4'h0, in_data[7:4]};
                cap_rem  = {4'h0, in_data[3:0]};
            end
        endcase
    end

    always_comb begin
        main_adj = {add3(main_bcd[11:8]), add3(main_bcd[7:4]), add3(main_bcd[3:0])};
        main_nxt = {main_adj[10:0], main_sh[7]};
        rem_adj  = {add3(rem_bcd[7:4]), add3(rem_bcd[3:0])};
        rem_nxt  = {rem_adj[6:0], rem_sh[7]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= 3'd0;
            main_sh   <= 8'd0;
            rem_sh    <= 8'd0;
            main_bcd  <= 12'd0;
            rem_bcd   <= 8'd0;
            neg_r     <= 1'b0;
            op_r      <= 2'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_bcd   <= 12'd0;
            out_rem   <= 8'd0;
            out_neg   <= 1'b0;
            out_op    <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        main_sh  <= cap_main;
                        rem_sh   <= cap_rem;
                        neg_r    <= cap_neg;
                        op_r     <= in_op;
                        main_bcd <= 12'd0;
                        rem_bcd  <= 8'd0;
                        count    <= 3'd0;
                        in_ready <= 1'b0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    main_bcd <= main_nxt;
                    rem_bcd  <= rem_nxt;
                    main_sh  <= {main_sh[6:0], 1'b0};
                    rem_sh   <= {rem_sh[6:0], 1'b0};
                    count    <= count + 3'd1;
                    // Eighth shift: publish the just-computed digits directly.
                    if (count == 3'd7) begin
                        out_bcd   <= main_nxt;
                        out_rem   <= rem_nxt;
                        out_neg   <= neg_r;
                        out_op    <= op_r;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
